nlm_cu_seq: RTL and testbench

//  Parametrised successor of the NLM calculation-unit front end. It snapshots OP_NUM register operand

---
 rtl/nlm_cu_seq_if.sv | 27 ++
 rtl/nlm_cu_seq.sv | 178 +++++++++++++++++
 tb/tb_nlm_cu_seq.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nlm_cu_seq_if.sv
// nlm_cu_seq_if: task trigger, operand snapshot inputs and per-slot result outputs
// between the sensor register bank and the NLM calculation-unit sequencer.
interface nlm_cu_seq_if #(
   parameter int unsigned OP_NUM = 6,
   parameter int unsigned ALU_SZ = 16
);
   logic                       i_cu_tsk_trg_i;
   logic [OP_NUM*ALU_SZ-1:0]   i_op0_vec;
   logic [OP_NUM*ALU_SZ-1:0]   i_op1_vec;
   logic [OP_NUM*2-1:0]        r_op_mode;
   logic [OP_NUM-1:0]          r_op1_chn;
   logic [OP_NUM*ALU_SZ-1:0]   o_cu_op_vec;
   logic                       o_cu_op_vld;
   logic                       o_cu_busy;
   logic                       o_cu_tsk_end;
   logic                       o_cu_trg_drop;

   modport master (
      output i_cu_tsk_trg_i, i_op0_vec, i_op1_vec, r_op_mode, r_op1_chn,
      input  o_cu_op_vec, o_cu_op_vld, o_cu_busy, o_cu_tsk_end, o_cu_trg_drop
   );

   modport slave (
      input  i_cu_tsk_trg_i, i_op0_vec, i_op1_vec, r_op_mode, r_op1_chn,
      output o_cu_op_vec, o_cu_op_vld, o_cu_busy, o_cu_tsk_end, o_cu_trg_drop
   );
endinterface

// File: rtl/nlm_cu_seq.sv
// nlm_cu_seq: snapshots OP_NUM operand pairs per task and runs them slot by slot on one shared ALU.
// Define NLM_CU_SAT_EN for saturating results; otherwise results wrap to ALU_SZ bits.
module nlm_cu_seq #(
   parameter int unsigned OP_NUM   = 6,
   parameter int unsigned ALU_SZ   = 16,
   parameter int unsigned MUL_FRAC = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   nlm_cu_seq_if.slave bus
);
   localparam int unsigned IDX_WID = $clog2(OP_NUM);
   localparam int unsigned CNT_WID = $clog2(ALU_SZ);
   localparam logic [IDX_WID-1:0] LAST_IDX = IDX_WID'(OP_NUM - 1);
   localparam logic [CNT_WID-1:0] LAST_BIT = CNT_WID'(ALU_SZ - 1);
`ifdef NLM_CU_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, LOAD, EXEC, DONE} state_t;
   typedef enum logic [1:0] {OP_PASS, OP_ADD, OP_SUB, OP_MUL} op_t;

   state_t               state, state_nx;
   logic                 pend, pend_nx;
   logic                 drop;
   logic                 vld;
   logic [IDX_WID-1:0]   idx;
   logic [IDX_WID-1:0]   prv_idx;
   logic [CNT_WID-1:0]   mul_cnt;
   logic [2*ALU_SZ-1:0]  acc, acc_nx, prod_sh;
   logic [ALU_SZ-1:0]    op0_q [OP_NUM];
   logic [ALU_SZ-1:0]    op1_q [OP_NUM];
   op_t                  mode_q [OP_NUM];
   logic [OP_NUM-1:0]    chn_q;
   logic [ALU_SZ-1:0]    res_q [OP_NUM];
   op_t                  cur_mode;
   logic [ALU_SZ-1:0]    op_a, op_b, alu_res;
   logic [ALU_SZ:0]      sum, diff;
   logic                 slot_done;

   // Operand fetch: a chained op1 reads the previous slot's register, which was written
   // at the end of that slot and therefore always belongs to the current task.
   always_comb begin
      cur_mode  = mode_q[idx];
      prv_idx   = (idx == '0) ? '0 : idx - 1'b1;
      op_a      = op0_q[idx];
      op_b      = (chn_q[idx] && (idx != '0)) ? res_q[prv_idx] : op1_q[idx];
      sum       = {1'b0, op_a} + {1'b0, op_b};
      diff      = {1'b0, op_a} - {1'b0, op_b};
      acc_nx    = acc + (op_b[mul_cnt] ? ({{ALU_SZ{1'b0}}, op_a} << mul_cnt) : '0);
      prod_sh   = acc_nx >> MUL_FRAC;
      slot_done = (state == EXEC) && ((cur_mode != OP_MUL) || (mul_cnt == LAST_BIT));
   end

   always_comb begin
      alu_res = op_a;
      case (cur_mode)
         OP_PASS: alu_res = op_a;
         OP_ADD:  alu_res = (SAT_EN && sum[ALU_SZ]) ? '1 : sum[ALU_SZ-1:0];
         OP_SUB:  alu_res = (SAT_EN && diff[ALU_SZ]) ? '0 : diff[ALU_SZ-1:0];
         OP_MUL:  alu_res = (SAT_EN && (prod_sh[2*ALU_SZ-1:ALU_SZ] != '0)) ? '1
                                                                          : prod_sh[ALU_SZ-1:0];
         default: alu_res = op_a;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pend  <= 1'b0;
      end else begin
         state <= state_nx;
         pend  <= pend_nx;
      end
   end

   // At most one queued task; a trigger in DONE with nothing queued parks in pend and IDLE
   // then launches it on the following cycle.
   always_comb begin
      state_nx = state;
      pend_nx  = pend;
      drop     = 1'b0;
      case (state)
         IDLE: begin
            if (pend) begin
               state_nx = LOAD;
               pend_nx  = bus.i_cu_tsk_trg_i;
            end else if (bus.i_cu_tsk_trg_i) begin
               state_nx = LOAD;
            end
         end
         LOAD, EXEC: begin
            if (state == LOAD)
               state_nx = EXEC;
            else if (slot_done && (idx == LAST_IDX))
               state_nx = DONE;
            if (bus.i_cu_tsk_trg_i) begin
               if (pend) drop = 1'b1;
               else      pend_nx = 1'b1;
            end
         end
         DONE: begin
            if (pend) begin
               state_nx = LOAD;
               pend_nx  = 1'b0;
               drop     = bus.i_cu_tsk_trg_i;
            end else begin
               state_nx = IDLE;
               pend_nx  = bus.i_cu_tsk_trg_i;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx     <= '0;
         mul_cnt <= '0;
         acc     <= '0;
      end else if (state == LOAD) begin
         idx     <= '0;
         mul_cnt <= '0;
         acc     <= '0;
      end else if (state == EXEC) begin
         if (slot_done) begin
            mul_cnt <= '0;
            acc     <= '0;
            if (idx != LAST_IDX) idx <= idx + 1'b1;
         end else begin
            mul_cnt <= mul_cnt + 1'b1;
            acc     <= acc_nx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < OP_NUM; k++) begin
            op0_q[k]  <= '0;
            op1_q[k]  <= '0;
            mode_q[k] <= OP_PASS;
            res_q[k]  <= '0;
         end
         chn_q <= '0;
      end else begin
         if (state == LOAD) begin
            for (int unsigned k = 0; k < OP_NUM; k++) begin
               op0_q[k]  <= bus.i_op0_vec[k*ALU_SZ +: ALU_SZ];
               op1_q[k]  <= bus.i_op1_vec[k*ALU_SZ +: ALU_SZ];
               mode_q[k] <= op_t'(bus.r_op_mode[k*2 +: 2]);
            end
            chn_q <= bus.r_op1_chn;
         end
         if (slot_done) res_q[idx] <= alu_res;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         vld <= 1'b0;
      else if (state_nx == LOAD)
         vld <= 1'b0;
      else if ((state == EXEC) && (state_nx == DONE))
         vld <= 1'b1;
   end

   always_comb begin
      for (int unsigned k = 0; k < OP_NUM; k++)
         bus.o_cu_op_vec[k*ALU_SZ +: ALU_SZ] = res_q[k];
      bus.o_cu_op_vld   = vld;
      bus.o_cu_busy     = (state != IDLE);
      bus.o_cu_tsk_end  = (state == DONE);
      bus.o_cu_trg_drop = drop;
   end
endmodule

// File: tb/tb_nlm_cu_seq.sv
// tb_nlm_cu_seq: directed literal scenarios plus randomized traffic, all checked against a
// cycle-level task model (busy window length, queue flag, arithmetic results per slot).
module tb_nlm_cu_seq;
   localparam int unsigned OP_NUM   = 6;
   localparam int unsigned ALU_SZ   = 16;
   localparam int unsigned MUL_FRAC = 4;
   localparam int unsigned VW       = OP_NUM * ALU_SZ;
`ifdef NLM_CU_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   t0 = 0;
   int   checks = 0;
   int   failures = 0;

   nlm_cu_seq_if #(.OP_NUM(OP_NUM), .ALU_SZ(ALU_SZ)) bus ();

   nlm_cu_seq #(.OP_NUM(OP_NUM), .ALU_SZ(ALU_SZ), .MUL_FRAC(MUL_FRAC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   // Task model: remaining busy cycles, queue flag, results computed from the LOAD-cycle inputs.
   int                m_left = 0;
   int                m_len = 0;
   bit                m_pend = 1'b0;
   bit                m_vld = 1'b0;
   bit                m_start = 1'b0;
   logic [ALU_SZ-1:0] m_res [OP_NUM];

   task automatic model_load();
      longint unsigned a, b, r;
      longint unsigned mask;
      mask  = (64'd1 << ALU_SZ) - 1;
      m_len = 2;
      for (int k = 0; k < OP_NUM; k++) begin
         a = 64'(bus.i_op0_vec[k*ALU_SZ +: ALU_SZ]);
         b = 64'(bus.i_op1_vec[k*ALU_SZ +: ALU_SZ]);
         if (k > 0 && bus.r_op1_chn[k]) b = 64'(m_res[k-1]);
         case (bus.r_op_mode[k*2 +: 2])
            2'd0: begin r = a; m_len += 1; end
            2'd1: begin
               r = a + b;
               if (r > mask) r = SAT ? mask : (r & mask);
               m_len += 1;
            end
            2'd2: begin
               if (a >= b) r = a - b;
               else        r = SAT ? 64'd0 : ((a - b) & mask);
               m_len += 1;
            end
            default: begin
               r = (a * b) >> MUL_FRAC;
               if (r > mask) r = SAT ? mask : (r & mask);
               m_len += ALU_SZ;
            end
         endcase
         m_res[k] = r[ALU_SZ-1:0];
      end
   endtask

   always @(negedge clk) begin
      logic [VW-1:0] ev;
      bit t;
      if (!rst_n) begin
         m_left = 0; m_pend = 0; m_vld = 0; m_start = 0;
         for (int k = 0; k < OP_NUM; k++) m_res[k] = '0;
         chk("rst_busy", bus.o_cu_busy, 0);
         chk("rst_vld", bus.o_cu_op_vld, 0);
         chk("rst_end", bus.o_cu_tsk_end, 0);
         chk("rst_drop", bus.o_cu_trg_drop, 0);
         chk("rst_vec", bus.o_cu_op_vec, 0);
      end else begin
         t = bus.i_cu_tsk_trg_i;
         if (m_start) begin
            model_load();
            m_left  = m_len;
            m_start = 0;
            m_vld   = 0;
         end
         if (m_left == 1) m_vld = 1;
         chk("busy", bus.o_cu_busy, (m_left > 0));
         chk("tsk_end", bus.o_cu_tsk_end, (m_left == 1));
         chk("trg_drop", bus.o_cu_trg_drop, (t && m_pend && m_left > 0));
         chk("op_vld", bus.o_cu_op_vld, m_vld);
         if (m_vld) begin
            for (int k = 0; k < OP_NUM; k++) ev[k*ALU_SZ +: ALU_SZ] = m_res[k];
            chk("op_vec", bus.o_cu_op_vec, ev);
         end
         if (m_left > 0) begin
            if (m_left == 1) begin
               if (m_pend) begin m_pend = 0; m_start = 1; end
               else if (t) m_pend = 1;
            end else if (t && !m_pend) begin
               m_pend = 1;
            end
            m_left--;
         end else if (m_pend) begin
            m_start = 1;
            m_pend  = t;
         end else if (t) begin
            m_start = 1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_inputs();
      for (int k = 0; k < OP_NUM; k++) begin
         logic [1:0] m;
         m = 2'($urandom_range(0, 3));
         if (m == 2'd3 && $urandom_range(0, 2) != 0) m = 2'd1;
         bus.r_op_mode[k*2 +: 2] = m;
         bus.i_op0_vec[k*ALU_SZ +: ALU_SZ] = ($urandom_range(0, 1) == 1) ?
            ALU_SZ'($urandom) : ALU_SZ'($urandom_range(0, 255));
         bus.i_op1_vec[k*ALU_SZ +: ALU_SZ] = ($urandom_range(0, 1) == 1) ?
            ALU_SZ'($urandom) : ALU_SZ'($urandom_range(0, 255));
      end
      bus.r_op1_chn = OP_NUM'($urandom);
   endtask

   task automatic setup_t1();
      rand_inputs();
      bus.r_op_mode = {OP_NUM{2'b01}};
      bus.r_op1_chn = '0;
      bus.i_op0_vec[15:0] = 16'h0010;
      bus.i_op1_vec[15:0] = 16'h0020;
   endtask

   // Pulses the trigger in relative cycle 0; returns relative cycles of tsk_end and first busy.
   task automatic run_task(input int mut, output int endc, output int fb, output int nb);
      bus.i_cu_tsk_trg_i = 1'b1;
      t0 = cyc; endc = -1; fb = -1; nb = 0;
      for (int i = 0; i < 200 && endc < 0; i++) begin
         @(negedge clk);
         if (bus.o_cu_busy) begin
            nb++;
            if (fb < 0) fb = cyc - t0;
         end
         if (bus.o_cu_tsk_end) endc = cyc - t0;
         step();
         bus.i_cu_tsk_trg_i = 1'b0;
         if (cyc - t0 == mut) rand_inputs();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int e, fb, nb;
      int unsigned dm, em, vm, bm;
      logic [ALU_SZ-1:0] keep [OP_NUM];
      bus.i_cu_tsk_trg_i = 1'b0;
      bus.i_op0_vec = '0;
      bus.i_op1_vec = '0;
      bus.r_op_mode = '0;
      bus.r_op1_chn = '0;
      repeat (3) step();
      rst_n = 1'b1;
      step();

      // 1: all ADD
      setup_t1();
      run_task(-1, e, fb, nb);
      chk("t1_end_cycle", e, 8);
      chk("t1_first_busy", fb, 1);
      chk("t1_busy_cycles", nb, 8);
      chk("t1_slot0", bus.o_cu_op_vec[15:0], 16'h0030);
      repeat (2) step();

      // 2: ADD overflow and SUB underflow
      setup_t1();
      bus.r_op_mode[3:0] = 4'b1001;
      bus.i_op0_vec[31:0] = {16'h0005, 16'hFFFF};
      bus.i_op1_vec[31:0] = {16'h0009, 16'h0002};
      run_task(-1, e, fb, nb);
      chk("t2_add", bus.o_cu_op_vec[15:0], SAT ? 16'hFFFF : 16'h0001);
      chk("t2_sub", bus.o_cu_op_vec[31:16], SAT ? 16'h0000 : 16'hFFFC);
      repeat (2) step();

      // 3: MUL slot plus PASS slots, inputs scrambled mid-task
      rand_inputs();
      bus.r_op_mode = {{(OP_NUM-1){2'b00}}, 2'b11};
      bus.i_op0_vec[15:0] = 16'h0030;
      bus.i_op1_vec[15:0] = 16'h0040;
      for (int k = 0; k < OP_NUM; k++) keep[k] = bus.i_op0_vec[k*ALU_SZ +: ALU_SZ];
      run_task(3, e, fb, nb);
      chk("t3_end_cycle", e, 23);
      chk("t3_slot0", bus.o_cu_op_vec[15:0], 16'h00C0);
      for (int k = 1; k < OP_NUM; k++)
         chk("t3_pass", bus.o_cu_op_vec[k*ALU_SZ +: ALU_SZ], keep[k]);
      repeat (2) step();

      // 4: chaining
      setup_t1();
      bus.r_op1_chn = 6'b000010;
      bus.i_op0_vec[31:16] = 16'h0001;
      bus.i_op1_vec[31:16] = 16'h5555;
      run_task(-1, e, fb, nb);
      chk("t4_chain", bus.o_cu_op_vec[31:16], 16'h0031);
      repeat (2) step();

      // 5: queue and drop
      setup_t1();
      bus.i_cu_tsk_trg_i = 1'b1;
      t0 = cyc; dm = 0; em = 0; vm = 0; bm = 0;
      for (int i = 0; i <= 20; i++) begin
         @(negedge clk);
         if (bus.o_cu_trg_drop) dm |= (32'd1 << i);
         if (bus.o_cu_tsk_end)  em |= (32'd1 << i);
         if (bus.o_cu_op_vld)   vm |= (32'd1 << i);
         if (bus.o_cu_busy)     bm |= (32'd1 << i);
         step();
         bus.i_cu_tsk_trg_i = (i + 1 == 3) || (i + 1 == 5);
      end
      chk("t5_drop", dm, 32'h0000_0020);
      chk("t5_end", em, 32'h0001_0100);
      chk("t5_busy", bm, 32'h0001_FFFE);
      chk("t5_vld_8_9", (vm >> 8) & 32'd3, 32'd1);

      // 6: reset during MUL execution
      rand_inputs();
      bus.r_op_mode[1:0] = 2'b11;
      bus.i_cu_tsk_trg_i = 1'b1;
      step();
      bus.i_cu_tsk_trg_i = 1'b0;
      repeat (4) step();
      #2 rst_n = 1'b0;
      #1;
      chk("t6_busy", bus.o_cu_busy, 0);
      chk("t6_vld", bus.o_cu_op_vld, 0);
      chk("t6_end", bus.o_cu_tsk_end, 0);
      chk("t6_vec", bus.o_cu_op_vec, 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      step();
      setup_t1();
      run_task(-1, e, fb, nb);
      chk("t6_end_cycle", e, 8);
      chk("t6_slot0", bus.o_cu_op_vec[15:0], 16'h0030);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) rand_inputs();
         bus.i_cu_tsk_trg_i = ($urandom_range(0, 9) == 0);
         step();
      end
      bus.i_cu_tsk_trg_i = 1'b0;
      for (int i = 0; i < 300 && (bus.o_cu_busy || m_pend || m_start); i++) step();
      chk("drain_idle", bus.o_cu_busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
